hid_encoder: RTL and testbench

Event-to-byte-stream encoder producing the framed HID link format consumed by the core's HID receiver. Keyboard matrix events and mouse motion/button reports enter on simple handshakes. They leave as paced messages on a strobe/start/data byte interface. The block sits on the IO-MCU side of the link, and in loopback/test builds it drives the receiver directly.

---
 rtl/hid_encoder.sv | 180 ++++++++++++++++++
 tb/tb_hid_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hid_encoder
// Description : Encodes keyboard matrix events and mouse motion/button
//               reports into paced, framed HID byte messages
//               (strobe/start/data). Key: 0x01,code. Mouse: 0x02,btns,dx,dy.
// Revision    : 1.0 - initial release
// ============================================================================
module hid_encoder #(
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  input  logic       mouse_valid,
  input  logic [1:0] mouse_btns,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam logic [7:0] C_GAP_RELOAD = 8'(GAP - 1);
  localparam logic [7:0] C_KEY_ID     = 8'h01;
  localparam logic [7:0] C_MOUSE_ID   = 8'h02;

  // State names the byte most recently placed on the output register.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B1, S_B2, S_B3} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_gap;
  logic [7:0] r_tx_key, r_tx_dx, r_tx_dy;
  logic [1:0] r_tx_btns;
  logic       r_is_mouse;
  logic       r_prefer_mouse;
  logic [7:0] r_acc_dx, r_acc_dy;
  logic [1:0] r_cur_btns, r_sent_btns;
  logic       r_strobe, r_start;
  logic [7:0] r_data;

  logic       w_gap_done, w_last, w_can_start, w_arb;
  logic       w_mouse_pend, w_sel_key, w_sel_mouse;
  logic       w_emit, w_emit_start;
  logic [7:0] w_emit_data;

  // Signed 8-bit add, clamped to -128..127.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

  assign w_gap_done   = (r_gap == 8'd0);
  // The final byte's state hands straight over to arbitration once the gap
  // expires, so back-to-back messages keep exact GAP spacing (even GAP=1).
  assign w_last       = ((r_state == S_B1) && !r_is_mouse) || (r_state == S_B3);
  assign w_can_start  = w_gap_done && ((r_state == S_IDLE) || w_last);
  assign w_arb        = w_can_start && !reset;
  assign w_mouse_pend = (r_acc_dx != 8'd0) || (r_acc_dy != 8'd0) || (r_cur_btns != r_sent_btns);
  assign w_sel_key    = w_arb && key_valid && (!w_mouse_pend || !r_prefer_mouse);
  assign w_sel_mouse  = w_arb && w_mouse_pend && (!key_valid || r_prefer_mouse);

  assign key_ready       = w_sel_key;
  assign data_out_strobe = r_strobe;
  assign data_out_start  = r_start;
  assign data_out        = r_data;
  assign busy            = !w_can_start;

  // Next-state and next output byte selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_emit_start = 1'b0;
    w_emit_data  = r_data;
    if (w_sel_key) begin
      w_state_nxt  = S_HDR;
      w_emit       = 1'b1;
      w_emit_start = 1'b1;
      w_emit_data  = C_KEY_ID;
    end else if (w_sel_mouse) begin
      w_state_nxt  = S_HDR;
      w_emit       = 1'b1;
      w_emit_start = 1'b1;
      w_emit_data  = C_MOUSE_ID;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_HDR: if (w_gap_done) begin
          w_state_nxt = S_B1;
          w_emit      = 1'b1;
          w_emit_data = r_is_mouse ? {6'b0, r_tx_btns} : r_tx_key;
        end
        S_B1: if (w_gap_done) begin
          if (r_is_mouse) begin
            w_state_nxt = S_B2;
            w_emit      = 1'b1;
            w_emit_data = r_tx_dx;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_B2: if (w_gap_done) begin
          w_state_nxt = S_B3;
          w_emit      = 1'b1;
          w_emit_data = r_tx_dy;
        end
        S_B3: if (w_gap_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, gap counter and registered byte interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gap    <= 8'd0;
      r_strobe <= 1'b0;
      r_start  <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_emit;
      r_start  <= w_emit_start;
      if (w_emit) begin
        r_data <= w_emit_data;
        r_gap  <= C_GAP_RELOAD;
      end else if (r_gap != 8'd0) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end

  // Message snapshot registers and round-robin fairness bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_key       <= 8'h00;
      r_tx_btns      <= 2'b00;
      r_tx_dx        <= 8'h00;
      r_tx_dy        <= 8'h00;
      r_is_mouse     <= 1'b0;
      r_prefer_mouse <= 1'b0;
      r_sent_btns    <= 2'b00;
    end else if (w_sel_key) begin
      r_tx_key       <= key_code;
      r_is_mouse     <= 1'b0;
      r_prefer_mouse <= 1'b1;
    end else if (w_sel_mouse) begin
      r_tx_btns      <= r_cur_btns;
      r_tx_dx        <= r_acc_dx;
      r_tx_dy        <= r_acc_dy;
      r_is_mouse     <= 1'b1;
      r_prefer_mouse <= 1'b0;
      r_sent_btns    <= r_cur_btns;
    end
  end

  // Mouse accumulators; a report arriving on a snapshot cycle starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_dx   <= 8'h00;
      r_acc_dy   <= 8'h00;
      r_cur_btns <= 2'b00;
    end else if (mouse_valid) begin
      r_acc_dx   <= sat_add(w_sel_mouse ? 8'h00 : r_acc_dx, mouse_dx);
      r_acc_dy   <= sat_add(w_sel_mouse ? 8'h00 : r_acc_dy, mouse_dy);
      r_cur_btns <= mouse_btns;
    end else if (w_sel_mouse) begin
      r_acc_dx <= 8'h00;
      r_acc_dy <= 8'h00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hid_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hid_encoder
// Description : Self-checking bench for hid_encoder; a scheduling model
//               predicts every strobe, byte, key_ready and busy per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hid_encoder;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ready;
  logic       mouse_valid = 1'b0;
  logic [1:0] mouse_btns = 2'b00;
  logic [7:0] mouse_dx = 8'h00;
  logic [7:0] mouse_dy = 8'h00;
  logic       data_out_strobe;
  logic       data_out_start;
  logic [7:0] data_out;
  logic       busy;

  hid_encoder #(.GAP(G)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .mouse_valid(mouse_valid), .mouse_btns(mouse_btns),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .data_out_strobe(data_out_strobe), .data_out_start(data_out_start),
    .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected strobe schedule plus accumulator arithmetic.
  typedef struct { int cyc; int b; bit s; } ev_t;
  ev_t q[$];
  bit  run = 1'b0;
  int  cyc = 0;
  int  m_last = -1000;      // cycle of the last scheduled byte
  int  m_dx = 0, m_dy = 0;
  int  m_cur = 0, m_sent = 0;
  bit  m_pm = 1'b0;         // 1: mouse is owed the next contested slot
  int  last_data = 0;
  int  c;
  bit  exp_s, pend, free_slot, sk, sm;

  function automatic int sat(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  always @(negedge clk) begin
    if (run) begin
      c = cyc;
      cyc++;
      exp_s = (q.size() > 0) && (q[0].cyc == c);
      check("strobe", data_out_strobe, exp_s);
      if (exp_s) begin
        last_data = q[0].b;
        check("start", data_out_start, q[0].s);
        void'(q.pop_front());
      end else begin
        check("start_no_strobe", data_out_start, 0);
      end
      check("data_out", data_out, last_data);
      free_slot = (c >= m_last + G - 1);
      check("busy", busy, !free_slot);
      if (reset) begin
        check("key_ready_in_reset", key_ready, 0);
        q.delete();
        m_last = -1000; m_dx = 0; m_dy = 0; m_cur = 0; m_sent = 0;
        m_pm = 1'b0; last_data = 0;
      end else begin
        pend = (m_dx != 0) || (m_dy != 0) || (m_cur != m_sent);
        sk = free_slot && key_valid && (!pend || !m_pm);
        sm = free_slot && pend && (!key_valid || m_pm);
        check("key_ready", key_ready, sk);
        if (sk) begin
          q.push_back('{c + 1, 1, 1'b1});
          q.push_back('{c + 1 + G, int'(key_code), 1'b0});
          m_last = c + 1 + G;
          m_pm = 1'b1;
        end else if (sm) begin
          q.push_back('{c + 1, 2, 1'b1});
          q.push_back('{c + 1 + G, m_cur, 1'b0});
          q.push_back('{c + 1 + 2 * G, m_dx & 255, 1'b0});
          q.push_back('{c + 1 + 3 * G, m_dy & 255, 1'b0});
          m_last = c + 1 + 3 * G;
          m_sent = m_cur;
          m_dx = 0; m_dy = 0;
          m_pm = 1'b0;
        end
        if (mouse_valid) begin
          m_dx  = sat(m_dx + int'($signed(mouse_dx)));
          m_dy  = sat(m_dy + int'($signed(mouse_dy)));
          m_cur = int'(mouse_btns);
        end
      end
    end
  end

  // One cycle: observe the handshake, then update inputs after the edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = key_valid && key_ready;
    @(posedge clk);
    #1;
    mouse_valid = 1'b0;
    if (acc) key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(a);
  endtask

  task automatic send_key(input logic [7:0] code);
    bit a;
    key_valid = 1'b1;
    key_code  = code;
    for (int i = 0; i < 200; i++) begin
      step(a);
      if (a) return;
    end
    check("key_accept_timeout", 0, 1);
    key_valid = 1'b0;
  endtask

  task automatic mouse(input logic [1:0] b, input logic [7:0] dx, input logic [7:0] dy);
    bit a;
    mouse_valid = 1'b1;
    mouse_btns  = b;
    mouse_dx    = dx;
    mouse_dy    = dy;
    step(a);
  endtask

  initial begin
    bit a;
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;
    idle(3);

    // single key
    send_key(8'h35);
    idle(20);

    // one mouse report
    mouse(2'b01, 8'h03, 8'hFE);
    idle(30);

    // saturation while a key message holds the link
    send_key(8'h11);
    repeat (5) mouse(2'b01, 8'h40, 8'h00);
    idle(30);
    send_key(8'h12);
    repeat (10) mouse(2'b01, 8'h00, 8'hC0);
    idle(40);

    // fairness: key always requesting, mouse reports interleaved
    key_valid = 1'b1;
    key_code  = 8'($urandom);
    for (int i = 0; i < 120; i++) begin
      if (!key_valid) begin
        key_valid = 1'b1;
        key_code  = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        mouse_valid = 1'b1;
        mouse_btns  = 2'($urandom);
        mouse_dx    = 8'($urandom_range(1, 20));
        mouse_dy    = 8'($urandom);
      end
      step(a);
    end
    key_valid = 1'b0;
    idle(40);

    // button-only change, then an identical repeat
    mouse(2'b10, 8'h00, 8'h00);
    idle(30);
    mouse(2'b10, 8'h00, 8'h00);
    idle(30);

    // reset between the mouse B1 and B2 strobes
    mouse(2'b01, 8'h05, 8'h07);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (data_out_strobe) n++;
    end
    check("b1_strobe_seen", n, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(a);
    reset = 1'b0;
    idle(2);
    send_key(8'h22);
    idle(20);

    // random traffic, including keys withdrawn before acceptance
    for (int i = 0; i < 400; i++) begin
      if (!key_valid && $urandom_range(0, 3) == 0) begin
        key_valid = 1'b1;
        key_code  = 8'($urandom);
      end else if (key_valid && $urandom_range(0, 15) == 0) begin
        key_valid = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        mouse_valid = 1'b1;
        mouse_btns  = 2'($urandom);
        mouse_dx    = 8'($urandom);
        mouse_dy    = 8'($urandom);
      end
      step(a);
    end
    key_valid = 1'b0;
    idle(60);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
